neuron_mac_acc: RTL and testbench



---
 rtl/neuron_mac_acc_pkg.sv | 46 ++++
 rtl/neuron_mac_acc_round.sv | 22 ++
 rtl/neuron_mac_acc.sv | 127 ++++++++++++
 tb/tb_neuron_mac_acc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_acc_pkg.sv
// Shared Q6.9 fixed-point definitions for the neuron datapath.
// Latency: n/a (constants, types and a combinational helper).
// Backpressure: n/a.
package neuron_mac_acc_pkg;

   localparam int Q_DATA_W = 16;
   localparam int Q_FRAC_W = 9;

   localparam logic [Q_DATA_W-1:0] Q_ONE = 16'h0200;
   localparam logic [Q_DATA_W-1:0] Q_MAX = 16'h7FFF;
   localparam logic [Q_DATA_W-1:0] Q_MIN = 16'h8000;

   typedef enum logic [1:0] {
      ST_ACC,
      ST_FLUSH,
      ST_ROUND,
      ST_HOLD
   } state_t;

   // Round half up to dw-bit fixed point with fw fractional bits, clipping
   // to the signed dw-bit range; sat reports whether clipping happened.
   // dw and fw are elaboration constants at every call site.
   function automatic logic signed [63:0] round_sat(
      input  logic signed [63:0] acc,
      input  int                 dw,
      input  int                 fw,
      output logic               sat
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r   = (acc + (64'sd1 <<< (fw - 1))) >>> fw;
      hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (dw - 1));
      sat = 1'b0;
      if (r > hi) begin
         r   = hi;
         sat = 1'b1;
      end else if (r < lo) begin
         r   = lo;
         sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/neuron_mac_acc_round.sv
// Rounds a wide signed accumulator down to DATA_W fixed point, with clip flag.
// Latency: combinational.
// Backpressure: none; pure function of acc.
module q_round_sat
   import neuron_mac_acc_pkg::*;
#(
   parameter int ACC_W  = 40,
   parameter int DATA_W = Q_DATA_W,
   parameter int FRAC_W = Q_FRAC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic        [DATA_W-1:0] q,
   output logic                     sat
);

   // Sign-extend to the helper's working width, round, clip, truncate.
   always_comb begin
      sat = 1'b0;
      q   = DATA_W'(round_sat(64'(acc), DATA_W, FRAC_W, sat));
   end

endmodule

// File: rtl/neuron_mac_acc.sv
// Neuron pre-activation: bias + sum(data*weight) over N_INPUTS beats, Q6.9 out.
// Latency: result visible 2 edges after the edge accepting the last beat.
// Backpressure: in_ready drops from last beat until the result is taken; no overlap.
module neuron_mac_acc
   import neuron_mac_acc_pkg::*;
#(
   parameter int N_INPUTS = 16,
   parameter int DATA_W   = Q_DATA_W,
   parameter int FRAC_W   = Q_FRAC_W,
   parameter int ACC_W    = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_weight,
   input  logic [DATA_W-1:0] in_bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic signed [2*DATA_W-1:0] prod_reg;
   logic signed [2*DATA_W-1:0] prod_next;
   logic                       prod_pend;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    bias_acc;
   logic signed [ACC_W-1:0]    prod_acc;
   logic signed [DATA_W-1:0]   data_s;
   logic signed [DATA_W-1:0]   weight_s;
   logic signed [DATA_W-1:0]   bias_s;
   logic [DATA_W-1:0]          rs_data;
   logic                       rs_sat;
   logic                       accept;

   assign data_s    = in_data;
   assign weight_s  = in_weight;
   assign bias_s    = in_bias;
   assign prod_next = (2*DATA_W)'(data_s) * (2*DATA_W)'(weight_s);
   assign bias_acc  = ACC_W'(bias_s) <<< FRAC_W;
   assign prod_acc  = ACC_W'(prod_reg);

   // Ready only while collecting beats, and never while reset is held.
   assign in_ready = (state == ST_ACC) && !rst;
   assign accept   = in_valid && in_ready;

   q_round_sat #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
   ) u_round (
      .acc (acc),
      .q   (rs_data),
      .sat (rs_sat)
   );

   // Multiply stage plus accumulate of the previously registered product.
   // The bias load on a neuron's first beat never collides with a pending
   // product: the last product of the prior neuron is added in FLUSH.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_reg  <= '0;
         prod_pend <= 1'b0;
         acc       <= '0;
      end else begin
         prod_pend <= accept;
         if (accept) begin
            prod_reg <= prod_next;
         end
         if (accept && (cnt == '0)) begin
            acc <= bias_acc;
         end else if (prod_pend) begin
            acc <= acc + prod_acc;
         end
      end
   end

   // Control FSM: beat counting, flush, round and hold-until-taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACC;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (accept) begin
                  if (cnt == LAST_BEAT) begin
                     cnt   <= '0;
                     state <= ST_FLUSH;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               state <= ST_ROUND;
            end
            ST_ROUND: begin
               out_data  <= rs_data;
               out_sat   <= rs_sat;
               out_valid <= 1'b1;
               state     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_ACC;
               end
            end
            default: begin
               state <= ST_ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Scoreboard bench for neuron_mac_acc with four inputs per neuron.
// Latency: checks the 2-edge gap from last accept to out_valid.
// Backpressure: exercises input gaps, output stalls and mid-neuron reset.
module tb_neuron_mac_acc;
   import neuron_mac_acc_pkg::*;

   localparam int N = 4;

   typedef logic [15:0] vec_t [N];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic [15:0] in_weight = '0;
   logic [15:0] in_bias = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_sat;

   int errors = 0;
   int checks = 0;

   // {sat, data}
   logic [16:0] exp_q[$];

   neuron_mac_acc #(
      .N_INPUTS (N),
      .DATA_W   (16),
      .FRAC_W   (9),
      .ACC_W    (40)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_weight (in_weight),
      .in_bias   (in_bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // Exact integer reference: bias*2^9 + sum of products, round half up, clip.
   function automatic logic [16:0] model(input vec_t d, input vec_t w, input logic [15:0] b);
      longint s;
      longint r;
      s = longint'($signed(b)) * 512;
      for (int i = 0; i < N; i++) begin
         s += longint'($signed(d[i])) * longint'($signed(w[i]));
      end
      r = (s + 256) >>> 9;
      if (r > 32767)  return {1'b1, Q_MAX};
      if (r < -32768) return {1'b1, Q_MIN};
      return {1'b0, r[15:0]};
   endfunction

   task automatic send_beat(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_weight = w;
      in_bias   = b;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("beat_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Bias is only meaningful on beat 0; later beats carry random bias values.
   task automatic send_neuron(input vec_t d, input vec_t w, input logic [15:0] b,
                              input int max_gap, input bit push);
      if (push) exp_q.push_back(model(d, w, b));
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         send_beat(d[i], w[i], (i == 0) ? b : 16'($urandom));
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: compare each result on the cycle it is handed over.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[15:0]));
            check("out_sat", 32'(out_sat), 32'(e[16]));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t ones, d, w;
      int n;
      ones = '{default: 16'h0200};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 4 x (1.0 * 1.0) = 4.0, with latency check
      send_neuron(ones, ones, 16'h0000, 0, 1'b1);
      @(negedge clk);
      check("lat_e0_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_e1_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("lat_e2_valid", 32'(out_valid), 32'd1);
      wait_drain();

      // 4 x (1.0 * -1.0) - 0.5 = -4.5
      w = '{default: 16'hFE00};
      send_neuron(ones, w, 16'hFF00, 0, 1'b1);
      wait_drain();

      // Positive and negative saturation
      d = '{default: 16'h7FFF};
      send_neuron(d, d, 16'h0000, 0, 1'b1);
      wait_drain();
      w = '{default: 16'h8000};
      send_neuron(d, w, 16'h0000, 0, 1'b1);
      wait_drain();

      // Rounding: +half rounds up to 1 LSB, -half rounds up to 0
      d = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
      w = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
      send_neuron(d, w, 16'h0000, 0, 1'b1);
      wait_drain();
      w = '{16'hFF00, 16'h0000, 16'h0000, 16'h0000};
      send_neuron(d, w, 16'h0000, 0, 1'b1);
      wait_drain();

      // Random gaps between beats
      for (int k = 0; k < 3; k++) begin
         send_neuron(ones, ones, 16'h0000, 3, 1'b1);
         wait_drain();
      end

      // Output stall: result must hold and no beat may be taken
      out_ready = 1'b0;
      send_neuron(ones, ones, 16'h0100, 0, 1'b1);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("hold_reached", 32'(out_valid), 32'd1);
      in_valid  = 1'b1;
      in_data   = 16'h7FFF;
      in_weight = 16'h7FFF;
      in_bias   = 16'h7FFF;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         if (exp_q.size() != 0) check("hold_data", 32'(out_data), 32'(exp_q[0][15:0]));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      send_neuron(ones, ones, 16'h0000, 0, 1'b1);
      wait_drain();

      // Reset partway through a neuron
      send_beat(16'h7FFF, 16'h7FFF, 16'h7FFF);
      send_beat(16'h7FFF, 16'h7FFF, 16'h7FFF);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst_valid", 32'(out_valid), 32'd0);
         check("midrst_in_ready", 32'(in_ready), 32'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("postrst_valid", 32'(out_valid), 32'd0);
      end
      send_neuron(ones, ones, 16'h0000, 1, 1'b1);
      wait_drain();

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
